soc_cpu_3_div_cell: RTL and testbench
=====================================

# soc_cpu_3_div_cell

Iterative 32-bit integer divider for the cpu_3 M-stage, the inverse counterpart of the cpu_3 multiply cell. It computes `div`/`divu` quotients, and optionally remainders, with a radix-2 restoring algorithm over 32 iterations. The CPU pipeline stalls on `M_div_busy` and consumes the result on `M_div_done`.

## Interface

Parameters:
- `WIDTH`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1: sole clock. All state changes on its rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `M_div_start`  in  1: one-cycle request. Sampled only in IDLE.
- `M_div_signed`  in  1: 1 selects signed two's-complement (`div`), 0 selects unsigned (`divu`).
- `M_div_src1`  in  32: dividend.
- `M_div_src2`  in  32: divisor.
- `M_div_busy`  out  1: high while an operation is in flight.
- `M_div_done`  out  1: one-cycle pulse. Result is valid in that cycle.
- `M_div_cell_result`  out  32: quotient. Held until the next accepted start.
- `M_div_cell_rem`  out  32: remainder. Present only with `SOC_CPU_3_DIV_REM_EN`.

## Operation

- FSM states: IDLE, ITER, FIX, DONE.
- **IDLE**
  - On `M_div_start`: capture |src1| and |src2|. Absolute value is taken only when `M_div_signed` is 1.
  - Capture neg_q = signed & (src1[31] ^ src2[31]) and neg_r = signed & src1[31].
  - Clear the partial remainder, load count = 31, go to ITER.
- **ITER** (32 cycles)
  - rem' = {rem[30:0], dvd[31]}; dvd shifts left by 1.
  - If rem' >= dvs (33-bit compare): rem = rem' - dvs and the quotient bit is 1. Otherwise rem = rem' and the bit is 0.
  - Leave ITER when count == 0.
- **FIX**
  - result = neg_q ? -q : q; rem_out = neg_r ? -rem : rem. Both are 32-bit wraparound.
  - Go to DONE.
- **DONE**: `M_div_done` = 1 for one cycle, then return to IDLE.
- Divide by zero (no trap):
  - Unsigned: quotient = 0xFFFFFFFF, remainder = dividend. This falls out of the algorithm naturally.
  - Signed: the same values are forced in FIX, i.e. 0xFFFFFFFF and src1 unchanged.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraparound, no flag).
- `M_div_start` while busy or in DONE is ignored. Inputs need not be held after the start cycle.
- Reset at any time, including mid-operation:
  - FSM returns to IDLE.
  - `M_div_busy` = 0, `M_div_done` = 0, `M_div_cell_result` = 0, `M_div_cell_rem` = 0.
  - The partial computation is discarded.

## Timing

- Start accepted in cycle N:
  - `M_div_busy` is high in cycles N+1 through N+33 (32 ITER cycles plus FIX).
  - `M_div_done` is high in cycle N+34 only.
- Fixed latency of 34 cycles. Operand values have no effect on latency.
- Back-to-back operation: a start in cycle N+35 is accepted, giving a throughput of one divide per 35 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration

- `SOC_CPU_3_DIV_REM_EN` defined:
  - The `M_div_cell_rem` port and its sign-correction logic are compiled in.
  - The remainder is valid with `M_div_done`.
- Undefined:
  - The port is absent and the neg_r flag is removed.
  - The partial-remainder register is still required internally.
  - Quotient behaviour and timing are identical in both builds.

## Structure

- Package `soc_cpu_3_div_pkg` contains:
  - the state enum (IDLE, ITER, FIX, DONE);
  - `DIV_WIDTH` = 32;
  - `DIV_ITERS` = 32;
  - `DIV0_QUOTIENT` = 32'hFFFFFFFF.
- Sub-module `soc_cpu_3_div_step`: purely combinational single restoring step.
  - Inputs: rem, dvd MSB, dvs.
  - Outputs: next rem and quotient bit.
- The top level holds the FSM, counter, operand registers and sign fix-up.

## Test plan

- Unsigned 100 / 7, start in cycle 0 → done in cycle 34, result 14, rem 2. Busy in cycles 1–33.
- Signed -100 / 7 → result 0xFFFFFFF2 (-14), rem 0xFFFFFFFE (-2). Signed 100 / -7 → 0xFFFFFFF2, rem 2.
- Divide by zero, src1 = 0x12345678 / 0, both signed and unsigned → result 0xFFFFFFFF, rem 0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF → result 0x80000000, rem 0. Unsigned same operands → result 0, rem 0x80000000.
- Start pulsed again in cycle 10 with different operands → ignored. The first result appears in cycle 34 and there is exactly one done pulse.
- `reset_n` low in cycle 15 of an operation → busy, done and result read 0 immediately. A new start after release completes normally 34 cycles later.

Source files
------------

// File: rtl/soc_cpu_3_div_pkg.sv
// Shared types and constants for the cpu_3 iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package soc_cpu_3_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [CNT_W-1:0]     CNT_INIT      = CNT_W'(DIV_ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Magnitude of a two's-complement value; passthrough for unsigned operands.
    function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v,
                                                     input logic is_signed);
        return (is_signed && v[DIV_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/soc_cpu_3_div_step.sv
// One radix-2 restoring division step (shift in dividend MSB, trial subtract).
// Latency: combinational.
// Backpressure: none.
module soc_cpu_3_div_step
    import soc_cpu_3_div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem,
    input  logic                 dvd_msb,
    input  logic [DIV_WIDTH-1:0] dvs,
    output logic [DIV_WIDTH-1:0] rem_nxt,
    output logic                 q_bit
);

    // The shifted remainder needs 33 bits: rem can reach dvs-1 with dvs up to 2^32-1.
    // The difference is only used when shifted >= dvs, so it always fits in 32 bits.
    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH-1:0] diff;

    // Trial subtraction; keep the difference only when it does not go negative.
    always_comb begin
        shifted = {rem, dvd_msb};
        diff    = shifted[DIV_WIDTH-1:0] - dvs;
        q_bit   = (shifted >= {1'b0, dvs});
        rem_nxt = q_bit ? diff : shifted[DIV_WIDTH-1:0];
    end

endmodule

// File: rtl/soc_cpu_3_div_cell.sv
// cpu_3 M-stage iterative div/divu (quotient; remainder with SOC_CPU_3_DIV_REM_EN).
// Latency: fixed 34 cycles start->done; busy for 33 cycles after the start cycle.
// Backpressure: none; start is ignored while busy or done, one divide per 35 cycles.
module soc_cpu_3_div_cell
    import soc_cpu_3_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             M_div_start,
    input  logic             M_div_signed,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_cell_result
`ifdef SOC_CPU_3_DIV_REM_EN
    ,
    output logic [WIDTH-1:0] M_div_cell_rem
`endif
);

    div_state_t state, state_nxt;
    logic       busy_nxt, done_nxt;

    logic [CNT_W-1:0]     count;
    logic [DIV_WIDTH-1:0] dvd;      // dividend magnitude, becomes the quotient as bits shift in
    logic [DIV_WIDTH-1:0] dvs;      // divisor magnitude
    logic [DIV_WIDTH-1:0] rem;      // partial remainder
    logic                 neg_q;
    logic                 div0;
`ifdef SOC_CPU_3_DIV_REM_EN
    logic                 neg_r;
`endif

    logic [DIV_WIDTH-1:0] rem_step;
    logic                 q_bit;

    soc_cpu_3_div_step u_step (
        .rem     (rem),
        .dvd_msb (dvd[DIV_WIDTH-1]),
        .dvs     (dvs),
        .rem_nxt (rem_step),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; busy/done are derived from the next state so they can be registered.
    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (M_div_start) state_nxt = ITER;
            ITER: if (count == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == ITER) || (state_nxt == FIX);
        done_nxt = (state_nxt == DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            M_div_busy <= 1'b0;
            M_div_done <= 1'b0;
        end else begin
            M_div_busy <= busy_nxt;
            M_div_done <= done_nxt;
        end
    end

    // Operand capture, iteration datapath and sign fix-up of the results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count             <= '0;
            dvd               <= '0;
            dvs               <= '0;
            rem               <= '0;
            neg_q             <= 1'b0;
            div0              <= 1'b0;
            M_div_cell_result <= '0;
`ifdef SOC_CPU_3_DIV_REM_EN
            neg_r             <= 1'b0;
            M_div_cell_rem    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (M_div_start) begin
                        dvd   <= div_abs(M_div_src1, M_div_signed);
                        dvs   <= div_abs(M_div_src2, M_div_signed);
                        rem   <= '0;
                        count <= CNT_INIT;
                        neg_q <= M_div_signed & (M_div_src1[DIV_WIDTH-1] ^ M_div_src2[DIV_WIDTH-1]);
                        div0  <= (M_div_src2 == '0);
`ifdef SOC_CPU_3_DIV_REM_EN
                        neg_r <= M_div_signed & M_div_src1[DIV_WIDTH-1];
`endif
                    end
                end
                ITER: begin
                    dvd   <= {dvd[DIV_WIDTH-2:0], q_bit};
                    rem   <= rem_step;
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    // Divide by zero: the raw quotient is all ones, but a negative signed
                    // dividend would flip it, so pin it. The remainder fix-up already
                    // reproduces the original dividend in both modes.
                    if (div0) begin
                        M_div_cell_result <= DIV0_QUOTIENT;
                    end else begin
                        M_div_cell_result <= neg_q ? -dvd : dvd;
                    end
`ifdef SOC_CPU_3_DIV_REM_EN
                    M_div_cell_rem <= neg_r ? -rem : rem;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_cpu_3_div_cell.sv
// Self-checking bench for soc_cpu_3_div_cell (build with or without SOC_CPU_3_DIV_REM_EN).
// Latency: n/a.
// Backpressure: n/a.
module tb_soc_cpu_3_div_cell;

    logic        clk;
    logic        reset_n;
    logic        M_div_start;
    logic        M_div_signed;
    logic [31:0] M_div_src1;
    logic [31:0] M_div_src2;
    logic        M_div_busy;
    logic        M_div_done;
    logic [31:0] M_div_cell_result;
`ifdef SOC_CPU_3_DIV_REM_EN
    logic [31:0] M_div_cell_rem;
`endif

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    typedef struct packed {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } op_t;

    exp_t sb_q[$];
    int   tests;
    int   fails;

    soc_cpu_3_div_cell #(.WIDTH(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .M_div_start       (M_div_start),
        .M_div_signed      (M_div_signed),
        .M_div_src1        (M_div_src1),
        .M_div_src2        (M_div_src2),
        .M_div_busy        (M_div_busy),
        .M_div_done        (M_div_done),
        .M_div_cell_result (M_div_cell_result)
`ifdef SOC_CPU_3_DIV_REM_EN
        ,
        .M_div_cell_rem    (M_div_cell_rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference results, written from the RISC-V div/divu/rem/remu definitions.
    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endtask

    // Called #1 after a rising edge (cycle 0); returns #1 after the accepting edge (cycle 1).
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
        M_div_start  = 1'b1;
        M_div_signed = sgn;
        M_div_src1   = a;
        M_div_src2   = b;
        sb_q.push_back('{q: eq, r: er});
        @(posedge clk); #1;
        M_div_start  = 1'b0;
        M_div_signed = 1'($urandom);
        M_div_src1   = $urandom;
        M_div_src2   = $urandom;
    endtask

    // Records busy/done for cycles 1..40 of an operation and the outputs in the done cycle.
    task automatic observe(output logic [40:0] bh, output logic [40:0] dh,
                           output logic [31:0] res, output logic [31:0] rm);
        bh  = '0;
        dh  = '0;
        res = 32'hDEAD_DEAD;
        rm  = 32'hDEAD_DEAD;
        for (int c = 1; c <= 40; c++) begin
            bh[c] = M_div_busy;
            dh[c] = M_div_done;
            if (M_div_done) begin
                res = M_div_cell_result;
`ifdef SOC_CPU_3_DIV_REM_EN
                rm  = M_div_cell_rem;
`else
                rm  = 32'd0;
`endif
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [40:0] busy_profile();
        logic [40:0] v;
        v = '0;
        for (int c = 1; c <= 33; c++) v[c] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        reset_n      = 1'b0;
        M_div_start  = 1'b0;
        M_div_signed = 1'b0;
        M_div_src1   = 32'd0;
        M_div_src2   = 32'd0;
        #3;
        tests++;
        if (M_div_busy !== 1'b0 || M_div_done !== 1'b0 || M_div_cell_result !== 32'd0) begin
            fails++;
            $display("FAIL reset_state busy=%b done=%b result=%h, need 0/0/00000000",
                     M_div_busy, M_div_done, M_div_cell_result);
        end
`ifdef SOC_CPU_3_DIV_REM_EN
        tests++;
        if (M_div_cell_rem !== 32'd0) begin
            fails++;
            $display("FAIL reset_rem got=%h need=00000000", M_div_cell_rem);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        op_t         ops[16];
        logic [40:0] bh, dh;
        logic [31:0] res, rm, a, b, eq, er;
        exp_t        e;
        ops[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        ops[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};
        ops[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2};
        ops[3] = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        ops[4] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        ops[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        ops[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        ops[7] = '{1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C};
        for (int i = 8; i < 16; i++) begin
            a = $urandom;
            b = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
            model(1'(i % 3 == 0), a, b, eq, er);
            ops[i] = '{1'(i % 3 == 0), a, b, eq, er};
        end
        for (int i = 0; i < 16; i++) begin
            issue(ops[i].sgn, ops[i].a, ops[i].b, ops[i].q, ops[i].r);
            observe(bh, dh, res, rm);
            tests++;
            if (bh !== busy_profile()) begin
                fails++;
                $display("FAIL arith%0d_busy got=%h need=%h", i, bh, busy_profile());
            end
            tests++;
            if (dh !== (41'd1 << 34)) begin
                fails++;
                $display("FAIL arith%0d_done got=%h need=%h", i, dh, 41'd1 << 34);
            end
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL arith%0d_scoreboard got=empty need=entry", i);
            end else begin
                e = sb_q.pop_front();
                tests++;
                if (res !== e.q) begin
                    fails++;
                    $display("FAIL arith%0d_quot sgn=%b a=%h b=%h got=%h need=%h",
                             i, ops[i].sgn, ops[i].a, ops[i].b, res, e.q);
                end
`ifdef SOC_CPU_3_DIV_REM_EN
                tests++;
                if (rm !== e.r) begin
                    fails++;
                    $display("FAIL arith%0d_rem sgn=%b a=%h b=%h got=%h need=%h",
                             i, ops[i].sgn, ops[i].a, ops[i].b, rm, e.r);
                end
`endif
            end
        end
    endtask

    task automatic test_ignored_start();
        int          done_cnt, done_cyc;
        logic [31:0] res;
        exp_t        e;
        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        M_div_start  = 1'b1;
        M_div_signed = 1'b0;
        M_div_src1   = 32'd500;
        M_div_src2   = 32'd3;
        @(posedge clk); #1;
        M_div_start  = 1'b0;
        done_cnt = 0;
        done_cyc = -1;
        res      = 32'hDEAD_DEAD;
        for (int c = 11; c <= 50; c++) begin
            if (M_div_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                res = M_div_cell_result;
            end
            @(posedge clk); #1;
        end
        e = sb_q.pop_front();
        tests++;
        if (done_cnt !== 1) begin
            fails++;
            $display("FAIL ignore_done_count got=%0d need=1", done_cnt);
        end
        tests++;
        if (done_cyc !== 34) begin
            fails++;
            $display("FAIL ignore_done_cycle got=%0d need=34", done_cyc);
        end
        tests++;
        if (res !== e.q) begin
            fails++;
            $display("FAIL ignore_result got=%h need=%h", res, e.q);
        end
    endtask

    task automatic test_reset_mid();
        logic [40:0] bh, dh;
        logic [31:0] res, rm, eq, er;
        exp_t        e;
        issue(1'b0, 32'hDEAD_BEEF, 32'd3, 32'd0, 32'd0);
        for (int c = 1; c < 15; c++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        // The in-flight divide is discarded, so its scoreboard entry goes too.
        void'(sb_q.pop_back());
        tests++;
        if (M_div_busy !== 1'b0 || M_div_done !== 1'b0 || M_div_cell_result !== 32'd0) begin
            fails++;
            $display("FAIL midreset_state busy=%b done=%b result=%h, need 0/0/00000000",
                     M_div_busy, M_div_done, M_div_cell_result);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        model(1'b0, 32'hDEAD_BEEF, 32'd3, eq, er);
        issue(1'b0, 32'hDEAD_BEEF, 32'd3, eq, er);
        observe(bh, dh, res, rm);
        e = sb_q.pop_front();
        tests++;
        if (dh !== (41'd1 << 34)) begin
            fails++;
            $display("FAIL midreset_done got=%h need=%h", dh, 41'd1 << 34);
        end
        tests++;
        if (res !== e.q) begin
            fails++;
            $display("FAIL midreset_quot got=%h need=%h", res, e.q);
        end
`ifdef SOC_CPU_3_DIV_REM_EN
        tests++;
        if (rm !== e.r) begin
            fails++;
            $display("FAIL midreset_rem got=%h need=%h", rm, e.r);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [40:0] bh, dh;
        logic [31:0] res, rm;
        exp_t        e;
        issue(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);
        for (int c = 1; c < 34; c++) begin
            @(posedge clk); #1;
        end
        e = sb_q.pop_front();
        tests++;
        if (M_div_done !== 1'b1 || M_div_cell_result !== e.q) begin
            fails++;
            $display("FAIL b2b_first done=%b result=%h, need 1/%h", M_div_done, M_div_cell_result, e.q);
        end
        // A start during the done cycle must be dropped; the one in the next cycle is taken.
        M_div_start  = 1'b1;
        M_div_signed = 1'b0;
        M_div_src1   = 32'd77;
        M_div_src2   = 32'd5;
        @(posedge clk); #1;
        tests++;
        if (M_div_busy !== 1'b0 || M_div_done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle busy=%b done=%b, need 0/0", M_div_busy, M_div_done);
        end
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        observe(bh, dh, res, rm);
        e = sb_q.pop_front();
        tests++;
        if (bh !== busy_profile()) begin
            fails++;
            $display("FAIL b2b_busy got=%h need=%h", bh, busy_profile());
        end
        tests++;
        if (dh !== (41'd1 << 34)) begin
            fails++;
            $display("FAIL b2b_done got=%h need=%h", dh, 41'd1 << 34);
        end
        tests++;
        if (res !== e.q) begin
            fails++;
            $display("FAIL b2b_quot got=%h need=%h", res, e.q);
        end
`ifdef SOC_CPU_3_DIV_REM_EN
        tests++;
        if (rm !== e.r) begin
            fails++;
            $display("FAIL b2b_rem got=%h need=%h", rm, e.r);
        end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_arith();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
